class_onehot_enc: RTL and testbench

Parametrised, streaming successor to the classifier's one-hot-to-binary encoder. It accepts one-hot class vectors from the final BNN popcount/argmax stage over a valid/ready handshake and emits a 1-based binary class index through a 2-entry skid buffer. Each result carries a per-result error flag, and a saturating error counter tracks malformed vectors. It sits between the argmax unit and the result/UART output path.

---
 rtl/class_onehot_enc.sv | 147 ++++++++++++++
 tb/tb_class_onehot_enc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/class_onehot_enc.sv
// class_onehot_enc: streaming one-hot to 1-based binary class index encoder.
// Accepts one-hot class vectors from the argmax stage over valid/ready and
// returns the encoded index through a 2-entry skid buffer (main + skid slot).
// Non-one-hot vectors produce idx 0 with out_err set and bump a saturating
// error counter.
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   in_valid/in_ready input handshake; in_ready is registered
//   in_classes        one-hot class vector, bit i = class i
//   out_valid/out_ready output handshake
//   out_idx, out_err  encoded class (i+1, 0 = invalid) and per-result error
//   clear_cnt         synchronous clear of err_cnt (wins over increment)
//   err_cnt           saturating count of accepted malformed vectors
//
// Optional feature macro: CLASS_ONEHOT_ENC_PRIORITY_EN
//   defined   : multi-hot encodes to lowest set bit + 1 (still flagged as error)
//   undefined : multi-hot encodes to 0 with error
module class_onehot_enc #(
  parameter int unsigned N_CLASSES = 10,
  parameter int unsigned IDX_W     = $clog2(N_CLASSES + 1),
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CLASSES-1:0] in_classes,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_err,
  input  logic                 clear_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             err;
  } res_t;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL1 = 2'd1;
  localparam logic [1:0] FULL2 = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0] state, state_nxt;
  res_t       main_q, main_nxt;
  res_t       skid_q, skid_nxt;
  logic       in_ready_nxt, out_valid_nxt;
  res_t       enc;
  logic       accept, deliver;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // Encoder: scan high to low so the last hit seen is the lowest set bit;
  // a second hit marks the vector as multi-hot.
  always_comb begin
    logic             hit;
    logic             multi;
    logic [IDX_W-1:0] low;
    hit   = 1'b0;
    multi = 1'b0;
    low   = '0;
    for (int i = N_CLASSES - 1; i >= 0; i--) begin
      if (in_classes[i]) begin
        if (hit) multi = 1'b1;
        hit = 1'b1;
        low = IDX_W'(i + 1);
      end
    end
    enc.err = !hit || multi;
`ifdef CLASS_ONEHOT_ENC_PRIORITY_EN
    enc.idx = hit ? low : '0;
`else
    enc.idx = (hit && !multi) ? low : '0;
`endif
  end

  // Next-state and slot-update logic derived from buffer occupancy.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      EMPTY: begin
        if (accept) begin
          main_nxt  = enc;
          state_nxt = FULL1;
        end
      end
      FULL1: begin
        if (accept && deliver) begin
          main_nxt = enc;
        end else if (accept) begin
          skid_nxt  = enc;
          state_nxt = FULL2;
        end else if (deliver) begin
          state_nxt = EMPTY;
        end
      end
      FULL2: begin
        if (deliver) begin
          main_nxt  = skid_q;
          state_nxt = FULL1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    in_ready_nxt  = (state_nxt != FULL2);
    out_valid_nxt = (state_nxt != EMPTY);
  end

  // State, slot and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      main_q    <= main_nxt;
      skid_q    <= skid_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  assign out_idx = main_q.idx;
  assign out_err = main_q.err;

  // Saturating error counter; clear takes priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (clear_cnt) begin
      err_cnt <= '0;
    end else if (accept && enc.err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_class_onehot_enc.sv
// Directed testbench for class_onehot_enc: main instance (N=10), a CNT_W=4
// instance for counter saturation and an N=200 instance for wide vectors.
module tb_class_onehot_enc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance
  logic       in_valid, in_ready, out_valid, out_ready, out_err, clear_cnt;
  logic [9:0] in_classes;
  logic [3:0] out_idx;
  logic [15:0] err_cnt;

  // saturation instance
  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err, s_clear;
  logic [9:0] s_classes;
  logic [3:0] s_idx;
  logic [3:0] s_err_cnt;

  // wide instance
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err, b_clear;
  logic [199:0] b_classes;
  logic [7:0]   b_idx;
  logic [15:0]  b_err_cnt;

  class_onehot_enc #(.N_CLASSES(10), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_classes(in_classes), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_err(out_err), .clear_cnt(clear_cnt), .err_cnt(err_cnt)
  );

  class_onehot_enc #(.N_CLASSES(10), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_classes(s_classes), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_idx(s_idx), .out_err(s_out_err), .clear_cnt(s_clear), .err_cnt(s_err_cnt)
  );

  class_onehot_enc #(.N_CLASSES(200), .CNT_W(16)) dut_big (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_classes(b_classes), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_idx(b_idx), .out_err(b_out_err), .clear_cnt(b_clear), .err_cnt(b_err_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [9:0]  cls;
    logic [3:0]  idx;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

`ifdef CLASS_ONEHOT_ENC_PRIORITY_EN
  localparam logic [3:0] MULTI_IDX = 4'd2;
`else
  localparam logic [3:0] MULTI_IDX = 4'd0;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    logic [199:0] bv;
    for (int k = 0; k < 10; k++) begin
      tbl[k].cls = 10'(1 << k);
      tbl[k].idx = 4'(k + 1);
      tbl[k].err = 1'b0;
      tbl[k].cnt = 16'd0;
    end
    tbl[10] = '{cls: 10'b0,          idx: 4'd0,      err: 1'b1, cnt: 16'd1};
    tbl[11] = '{cls: 10'b0000000110, idx: MULTI_IDX, err: 1'b1, cnt: 16'd2};

    rst = 1'b1;
    in_valid = 0; out_ready = 0; clear_cnt = 0; in_classes = '0;
    s_in_valid = 0; s_out_ready = 0; s_clear = 0; s_classes = '0;
    b_in_valid = 0; b_out_ready = 0; b_clear = 0; b_classes = '0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_out_err", 32'(out_err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 1);

    // table sweep, back-to-back with out_ready = 1
    out_ready = 1; in_valid = 1;
    for (int k = 0; k < 12; k++) begin
      in_classes = tbl[k].cls;
      tick();
      check($sformatf("vec%0d_valid", k), 32'(out_valid), 1);
      check($sformatf("vec%0d_idx", k), 32'(out_idx), 32'(tbl[k].idx));
      check($sformatf("vec%0d_err", k), 32'(out_err), 32'(tbl[k].err));
      check($sformatf("vec%0d_cnt", k), 32'(err_cnt), 32'(tbl[k].cnt));
      check($sformatf("vec%0d_ready", k), 32'(in_ready), 1);
    end
    in_valid = 0;
    tick();
    check("drain_valid", 32'(out_valid), 0);

    // backpressure: classes 3, 5, 7 offered with out_ready low
    out_ready = 0; in_valid = 1;
    in_classes = 10'b0000000100;
    tick();
    check("bp1_idx", 32'(out_idx), 3);
    check("bp1_ready", 32'(in_ready), 1);
    in_classes = 10'b0000010000;
    tick();
    check("bp2_ready", 32'(in_ready), 0);
    check("bp2_idx", 32'(out_idx), 3);
    in_classes = 10'b0001000000;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_stall_valid", 32'(out_valid), 1);
      check("bp_stall_idx", 32'(out_idx), 3);
      check("bp_stall_err", 32'(out_err), 0);
      check("bp_stall_ready", 32'(in_ready), 0);
    end
    out_ready = 1;
    tick();
    check("bp_rel_idx5", 32'(out_idx), 5);
    check("bp_rel_ready", 32'(in_ready), 1);
    tick();
    check("bp_rel_idx7", 32'(out_idx), 7);
    check("bp_rel_valid7", 32'(out_valid), 1);
    in_valid = 0;
    tick();
    check("bp_drain_valid", 32'(out_valid), 0);
    check("bp_err_cnt", 32'(err_cnt), 2);

    // reset while FULL2
    out_ready = 0; in_valid = 1;
    in_classes = 10'b0000000001;
    tick();
    in_classes = 10'b0000000010;
    tick();
    check("full2_ready", 32'(in_ready), 0);
    in_valid = 0;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_cnt", 32'(err_cnt), 0);
    tick();
    rst = 1'b0;
    out_ready = 1;
    tick();
    check("rst2_ready", 32'(in_ready), 1);
    check("rst2_valid", 32'(out_valid), 0);
    in_valid = 1; in_classes = 10'b0000010000;
    tick();
    check("rst2_idx", 32'(out_idx), 5);
    check("rst2_err", 32'(out_err), 0);
    in_valid = 0;
    tick();

    // saturation with CNT_W = 4
    s_out_ready = 1; s_in_valid = 1; s_classes = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("sat%0d_cnt", k), 32'(s_err_cnt), (k + 1 > 15) ? 15 : k + 1);
    end
    s_clear = 1;
    tick();
    check("sat_clear_cnt", 32'(s_err_cnt), 0);
    s_clear = 0;
    tick();
    check("sat_after_clear", 32'(s_err_cnt), 1);
    s_in_valid = 0;
    tick();

    // wide instance
    b_out_ready = 1; b_in_valid = 1;
    bv = '0; bv[199] = 1'b1;
    b_classes = bv;
    tick();
    check("big_idx200", 32'(b_idx), 200);
    check("big_err200", 32'(b_out_err), 0);
    bv = '0; bv[0] = 1'b1;
    b_classes = bv;
    tick();
    check("big_idx1", 32'(b_idx), 1);
    b_in_valid = 0;
    tick();
    check("big_cnt", 32'(b_err_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
